// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Buffers ALU commands in a small FIFO and issues them one at a time to a
//   combinational 4-bit ALU. Each issued command's result and flags are
//   captured and returned over a response channel. A command may optionally
//   replace operand A with the previously captured result (chaining).
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The producer holds valid and data stable until that edge. The
//   consumer may change ready freely.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_cmd_*                 command channel (valid, op, a, b, chain)
//   o_cmd_ready             FIFO not full (registered count only)
//   o_alu_a/b/ctrl          registered operands / op select to the ALU
//   i_alu_res/car/of        ALU result and flags
//   o_rsp_*, i_rsp_ready    response channel (valid, res, car, of, op)
//   o_busy                  FSM not idle or FIFO non-empty
//   o_count                 FIFO occupancy
//   o_of_cnt                saturating count of overflowing responses
//   o_state                 FSM state (0 idle, 1 issue, 2 resp)
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [2:0]                 i_cmd_op,
    input  logic [3:0]                 i_cmd_a,
    input  logic [3:0]                 i_cmd_b,
    input  logic                       i_cmd_chain,
    output logic [3:0]                 o_alu_a,
    output logic [3:0]                 o_alu_b,
    output logic [2:0]                 o_alu_ctrl,
    input  logic [3:0]                 i_alu_res,
    input  logic                       i_alu_car,
    input  logic                       i_alu_of,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [3:0]                 o_rsp_res,
    output logic                       o_rsp_car,
    output logic                       o_rsp_of,
    output logic [2:0]                 o_rsp_op,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [3:0]                 o_of_cnt,
    output logic [1:0]                 o_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_pop;
    logic            w_push;

    // FIFO entry layout: {op[11:9], a[8:5], b[4:1], chain[0]}
    logic [11:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [11:0]     w_head;

    logic [3:0]      r_alu_a;
    logic [3:0]      r_alu_b;
    logic [2:0]      r_alu_ctrl;
    logic [3:0]      r_last_res;
    logic [3:0]      r_rsp_res;
    logic            r_rsp_car;
    logic            r_rsp_of;
    logic [2:0]      r_rsp_op;
    logic [3:0]      r_of_cnt;

    assign o_cmd_ready = (r_count != CW'(DEPTH));
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and pop decision
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_next = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FIFO storage needs no reset: reads are gated by the occupancy count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_op, i_cmd_a, i_cmd_b, i_cmd_chain};
        end
    end

    // FIFO pointers, count, operand registers, response capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
            r_last_res <= '0;
            r_rsp_res  <= '0;
            r_rsp_car  <= 1'b0;
            r_rsp_of   <= 1'b0;
            r_rsp_op   <= '0;
            r_of_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                // Chain reads last_res as it stands at pop time; issue is
                // serial so this is the result of the preceding command.
                r_alu_a    <= w_head[0] ? r_last_res : w_head[8:5];
                r_alu_b    <= w_head[4:1];
                r_alu_ctrl <= w_head[11:9];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_state == ST_ISSUE) begin
                r_rsp_res  <= i_alu_res;
                r_rsp_car  <= i_alu_car;
                r_rsp_of   <= i_alu_of;
                r_rsp_op   <= r_alu_ctrl;
                r_last_res <= i_alu_res;
                if (i_alu_of && (r_of_cnt != 4'd15)) begin
                    r_of_cnt <= r_of_cnt + 4'd1;
                end
            end
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_ctrl  = r_alu_ctrl;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_res   = r_rsp_res;
    assign o_rsp_car   = r_rsp_car;
    assign o_rsp_of    = r_rsp_of;
    assign o_rsp_op    = r_rsp_op;
    assign o_busy      = (r_state != ST_IDLE) || (r_count != '0);
    assign o_count     = r_count;
    assign o_of_cnt    = r_of_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic          i_rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [2:0]    i_cmd_op;
    logic [3:0]    i_cmd_a;
    logic [3:0]    i_cmd_b;
    logic          i_cmd_chain;
    logic [3:0]    o_alu_a;
    logic [3:0]    o_alu_b;
    logic [2:0]    o_alu_ctrl;
    logic [3:0]    i_alu_res;
    logic          i_alu_car;
    logic          i_alu_of;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [3:0]    o_rsp_res;
    logic          o_rsp_car;
    logic          o_rsp_of;
    logic [2:0]    o_rsp_op;
    logic          o_busy;
    logic [CW-1:0] o_count;
    logic [3:0]    o_of_cnt;
    logic [1:0]    o_state;

    alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_a     (i_cmd_a),
        .i_cmd_b     (i_cmd_b),
        .i_cmd_chain (i_cmd_chain),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_ctrl  (o_alu_ctrl),
        .i_alu_res   (i_alu_res),
        .i_alu_car   (i_alu_car),
        .i_alu_of    (i_alu_of),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_res   (o_rsp_res),
        .o_rsp_car   (o_rsp_car),
        .o_rsp_of    (o_rsp_of),
        .o_rsp_op    (o_rsp_op),
        .o_busy      (o_busy),
        .o_count     (o_count),
        .o_of_cnt    (o_of_cnt),
        .o_state     (o_state)
    );

    // ---------------- behavioural ALU ----------------
    // sub: carry is the borrow out of a-b. compare: a<b unsigned. equal: a==b.
    always_comb begin
        i_alu_res = 4'd0;
        i_alu_car = 1'b0;
        i_alu_of  = 1'b0;
        case (o_alu_ctrl)
            3'd0: begin
                {i_alu_car, i_alu_res} = {1'b0, o_alu_a} + {1'b0, o_alu_b};
                i_alu_of = (o_alu_a[3] == o_alu_b[3]) && (i_alu_res[3] != o_alu_a[3]);
            end
            3'd1: begin
                {i_alu_car, i_alu_res} = {1'b0, o_alu_a} - {1'b0, o_alu_b};
                i_alu_of = (o_alu_a[3] != o_alu_b[3]) && (i_alu_res[3] != o_alu_a[3]);
            end
            3'd2: i_alu_res = ~o_alu_a;
            3'd3: i_alu_res = o_alu_a & o_alu_b;
            3'd4: i_alu_res = o_alu_a | o_alu_b;
            3'd5: i_alu_res = o_alu_a ^ o_alu_b;
            3'd6: i_alu_res = {3'b000, (o_alu_a < o_alu_b)};
            default: i_alu_res = {3'b000, (o_alu_a == o_alu_b)};
        endcase
    end

    // ---------------- scoreboard ----------------
    // expected response word: {op[8:6], res[5:2], car[1], of[0]}
    logic [8:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       chain;
        logic [3:0] res;
        logic       car;
        logic       ovf;
    } vec_t;

    vec_t bp_v[5];
    vec_t wrap_v[10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        i_cmd_op    = v.op;
        i_cmd_a     = v.a;
        i_cmd_b     = v.b;
        i_cmd_chain = v.chain;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic chain);
        int n;
        i_cmd_op    = op;
        i_cmd_a     = a;
        i_cmd_b     = b;
        i_cmd_chain = chain;
        i_cmd_valid = 1'b1;
        n = 0;
        while (!o_cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_cmd_ready) check("push_ready_timeout", o_cmd_ready, 1);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 100) begin
            tick();
            n++;
        end
        check(tag, o_busy, 0);
    endtask

    task automatic check_rsp(input string tag, input logic [8:0] e);
        check({tag, "_res"}, o_rsp_res, e[5:2]);
        check({tag, "_car"}, o_rsp_car, e[1]);
        check({tag, "_of"},  o_rsp_of,  e[0]);
        check({tag, "_op"},  o_rsp_op,  e[8:6]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int idx;
        int cyc;
        int pi;
        int ri;
        int n;
        int seen;
        logic do_push;
        logic do_rsp;
        logic [8:0] e;

        bp_v[0] = '{3'd0, 4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0};
        bp_v[1] = '{3'd1, 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0};
        bp_v[2] = '{3'd3, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0};
        bp_v[3] = '{3'd4, 4'b1100, 4'b0011, 1'b0, 4'b1111, 1'b0, 1'b0};
        bp_v[4] = '{3'd5, 4'b1111, 4'b0101, 1'b0, 4'b1010, 1'b0, 1'b0};

        wrap_v[0] = '{3'd0, 4'b0110, 4'b0101, 1'b0, 4'b1011, 1'b0, 1'b1};
        wrap_v[1] = '{3'd1, 4'b0010, 4'b0101, 1'b0, 4'b1101, 1'b1, 1'b0};
        wrap_v[2] = '{3'd2, 4'b1010, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0};
        wrap_v[3] = '{3'd3, 4'b0111, 4'b1101, 1'b0, 4'b0101, 1'b0, 1'b0};
        wrap_v[4] = '{3'd4, 4'b1000, 4'b0001, 1'b0, 4'b1001, 1'b0, 1'b0};
        wrap_v[5] = '{3'd5, 4'b0110, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0};
        wrap_v[6] = '{3'd6, 4'b0011, 4'b1000, 1'b0, 4'b0001, 1'b0, 1'b0};
        wrap_v[7] = '{3'd7, 4'b1001, 4'b1001, 1'b0, 4'b0001, 1'b0, 1'b0};
        wrap_v[8] = '{3'd0, 4'b1111, 4'b0010, 1'b1, 4'b0011, 1'b0, 1'b0};
        wrap_v[9] = '{3'd1, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};

        i_rst       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 3'd0;
        i_cmd_a     = 4'd0;
        i_cmd_b     = 4'd0;
        i_cmd_chain = 1'b0;
        i_rsp_ready = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_count",     o_count, 0);
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_res",   o_rsp_res, 0);
        check("rst_rsp_op",    o_rsp_op, 0);
        check("rst_alu_a",     o_alu_a, 0);
        check("rst_of_cnt",    o_of_cnt, 0);
        check("rst_busy",      o_busy, 0);
        check("rst_state",     o_state, 0);
        i_rst = 1'b0;

        // ---- single add, then chained add ----
        i_rsp_ready = 1'b1;
        drive('{3'd0, 4'b0011, 4'b0100, 1'b0, 4'b0, 1'b0, 1'b0});
        i_cmd_valid = 1'b1;
        tick();                                  // E0: accept
        i_cmd_valid = 1'b0;
        check("e0_count", o_count, 1);
        check("e0_rsp_valid", o_rsp_valid, 0);
        tick();                                  // E1: pop and load
        check("e1_alu_a", o_alu_a, 4'b0011);
        check("e1_alu_b", o_alu_b, 4'b0100);
        check("e1_alu_ctrl", o_alu_ctrl, 3'd0);
        check("e1_state", o_state, 1);
        check("e1_count", o_count, 0);
        tick();                                  // E2: capture
        check("e2_rsp_valid", o_rsp_valid, 1);
        check_rsp("add1", {3'd0, 4'b0111, 1'b0, 1'b0});

        drive('{3'd0, 4'b1111, 4'b0001, 1'b1, 4'b0, 1'b0, 1'b0});
        i_cmd_valid = 1'b1;
        tick();                                  // response consumed, chain cmd accepted
        i_cmd_valid = 1'b0;
        check("chain_rsp_gone", o_rsp_valid, 0);
        check("chain_count", o_count, 1);
        tick();
        check("chain_alu_a", o_alu_a, 4'b0111);
        check("chain_alu_b", o_alu_b, 4'b0001);
        tick();
        check("chain_rsp_valid", o_rsp_valid, 1);
        check_rsp("chain", {3'd0, 4'b1000, 1'b0, 1'b1});
        check("chain_of_cnt", o_of_cnt, 1);
        tick();
        check("chain_idle_busy", o_busy, 0);

        // ---- backpressure: DEPTH+1 accepts ----
        i_rsp_ready = 1'b0;
        i_cmd_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            idx = (acc < 5) ? acc : 4;
            drive(bp_v[idx]);
            if (o_cmd_ready) begin
                exp_q.push_back({bp_v[idx].op, bp_v[idx].res, bp_v[idx].car, bp_v[idx].ovf});
                acc++;
            end
            tick();
        end
        i_cmd_valid = 1'b0;
        check("bp_accepts", acc, 5);
        check("bp_count", o_count, 4);
        check("bp_cmd_ready", o_cmd_ready, 0);
        check("bp_rsp_valid", o_rsp_valid, 1);
        e = exp_q.pop_front();
        check_rsp("bp0", e);
        i_rsp_ready = 1'b1;
        tick();                                  // RESP -> IDLE, still full
        check("bp_rel_ready0", o_cmd_ready, 0);
        check("bp_rel_count4", o_count, 4);
        tick();                                  // pop frees an entry
        check("bp_rel_ready1", o_cmd_ready, 1);
        check("bp_rel_count3", o_count, 3);
        for (int r = 1; r < 5; r++) begin
            n = 0;
            while (!o_rsp_valid && n < 10) begin
                tick();
                n++;
            end
            check("bp_rsp_wait", o_rsp_valid, 1);
            e = exp_q.pop_front();
            check_rsp($sformatf("bp%0d", r), e);
            tick();
        end
        drain("bp_drain_busy");
        check("bp_q_empty", exp_q.size(), 0);

        // ---- simultaneous push/pop at count 2, order across wrap ----
        cyc = 0;
        pi  = 0;
        ri  = 0;
        i_rsp_ready = 1'b1;
        while (ri < 10 && cyc < 200) begin
            if (pi < 10 && cyc != 3) begin
                drive(wrap_v[pi]);
                i_cmd_valid = 1'b1;
            end else begin
                i_cmd_valid = 1'b0;
            end
            do_push = i_cmd_valid && o_cmd_ready;
            do_rsp  = o_rsp_valid && i_rsp_ready;
            if (cyc == 4) begin
                check("sim_pre_state", o_state, 0);
                check("sim_pre_count", o_count, 2);
            end
            if (do_rsp) begin
                if (exp_q.size() == 0) begin
                    check("wrap_spurious_rsp", o_rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_rsp($sformatf("wrap%0d", ri), e);
                end
                ri++;
            end
            if (do_push) begin
                exp_q.push_back({wrap_v[pi].op, wrap_v[pi].res, wrap_v[pi].car, wrap_v[pi].ovf});
                pi++;
            end
            tick();
            if (cyc == 4) check("sim_post_count", o_count, 2);
            cyc++;
        end
        i_cmd_valid = 1'b0;
        check("wrap_all_rsp", ri, 10);
        check("wrap_all_push", pi, 10);
        drain("wrap_drain_busy");
        check("wrap_of_cnt", o_of_cnt, 3);

        // ---- reset while in RESP with 3 queued ----
        i_rsp_ready = 1'b0;
        push_cmd(3'd5, 4'b1010, 4'b0110, 1'b0);
        push_cmd(3'd0, 4'b0001, 4'b0001, 1'b0);
        push_cmd(3'd3, 4'b1111, 4'b0101, 1'b0);
        push_cmd(3'd4, 4'b0010, 4'b0100, 1'b0);
        check("mid_state_resp", o_state, 2);
        check("mid_count", o_count, 3);
        check("mid_alu_a", o_alu_a, 4'b1010);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mrst_rsp_valid", o_rsp_valid, 0);
        check("mrst_count", o_count, 0);
        check("mrst_alu_a", o_alu_a, 0);
        check("mrst_alu_b", o_alu_b, 0);
        check("mrst_alu_ctrl", o_alu_ctrl, 0);
        check("mrst_of_cnt", o_of_cnt, 0);
        check("mrst_rsp_res", o_rsp_res, 0);
        check("mrst_busy", o_busy, 0);
        i_rsp_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (o_rsp_valid) seen++;
        end
        check("mrst_no_rsp", seen, 0);

        // ---- of_cnt saturation ----
        for (int k = 0; k < 17; k++) begin
            push_cmd(3'd0, 4'b0111, 4'b0001, 1'b0);
        end
        drain("sat_drain_busy");
        check("sat_of_cnt", o_of_cnt, 15);
        check("sat_last_of", o_rsp_of, 1);
        check("sat_last_res", o_rsp_res, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
